// File: rtl/auc_ecc_pkg.sv
// Shared ECC-core definitions: point-RAM address map, command opcodes,
// scheduler state encoding and the digit legality helper.
package auc_ecc_pkg;

  localparam int P_ADDR   = 5;
  localparam int P_WINDOW = 4;
  localparam int P_NLEN_W = 9;
  localparam int P_DIG_W  = 1 << (P_WINDOW - 2);

  localparam logic [P_ADDR-1:0] X_G    = 5'd0;
  localparam logic [P_ADDR-1:0] Y_G    = 5'd1;
  localparam logic [P_ADDR-1:0] ONERAM = 5'd19;
  localparam logic [P_ADDR-1:0] Z_G    = ONERAM;
  localparam logic [P_ADDR-1:0] X_3G   = 5'd2;
  localparam logic [P_ADDR-1:0] Y_3G   = 5'd3;
  localparam logic [P_ADDR-1:0] Z_3G   = 5'd4;
  localparam logic [P_ADDR-1:0] X_5G   = 5'd5;
  localparam logic [P_ADDR-1:0] Y_5G   = 5'd6;
  localparam logic [P_ADDR-1:0] Z_5G   = 5'd7;
  localparam logic [P_ADDR-1:0] X_7G   = 5'd8;
  localparam logic [P_ADDR-1:0] Y_7G   = 5'd9;
  localparam logic [P_ADDR-1:0] Z_7G   = 5'd10;
  localparam logic [P_ADDR-1:0] BLNK   = 5'd31;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_DBL  = 2'b01,
    OP_ADD  = 2'b10
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_RDWAIT   = 4'd2,
    ST_DECODE   = 4'd3,
    ST_DBL_REQ  = 4'd4,
    ST_DBL_WAIT = 4'd5,
    ST_PT_REQ   = 4'd6,
    ST_PT_WAIT  = 4'd7,
    ST_NEXT     = 4'd8,
    ST_FIN      = 4'd9
  } state_e;

  // A magnitude is legal when it is zero or has exactly one bit set.
  function automatic logic mag_illegal(input logic [P_DIG_W-1:0] mag);
    return (mag & (mag - {{(P_DIG_W-1){1'b0}}, 1'b1})) != {P_DIG_W{1'b0}};
  endfunction

endpackage

// File: rtl/auc_wmul_pdec.sv
// Registered NAF digit decoder: one-hot magnitude to precomputed-point
// RAM addresses plus sign/zero/illegal flags, captured when i_en is high.
module auc_wmul_pdec
  import auc_ecc_pkg::*;
#(
  parameter int ADDR = P_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [P_DIG_W:0] i_dig,
  output logic             o_sign,
  output logic             o_zero,
  output logic             o_illegal,
  output logic [ADDR-1:0]  o_x,
  output logic [ADDR-1:0]  o_y,
  output logic [ADDR-1:0]  o_z
);

  logic [P_DIG_W-1:0] w_mag;
  logic [ADDR-1:0]    w_x;
  logic [ADDR-1:0]    w_y;
  logic [ADDR-1:0]    w_z;

  assign w_mag = i_dig[P_DIG_W-1:0];

  // One-hot magnitude to point address lookup.
  always_comb begin
    w_x = BLNK;
    w_y = BLNK;
    w_z = BLNK;
    case (w_mag)
      4'b1000: begin w_x = X_G;  w_y = Y_G;  w_z = Z_G;  end
      4'b0100: begin w_x = X_3G; w_y = Y_3G; w_z = Z_3G; end
      4'b0010: begin w_x = X_5G; w_y = Y_5G; w_z = Z_5G; end
      4'b0001: begin w_x = X_7G; w_y = Y_7G; w_z = Z_7G; end
      default: begin w_x = BLNK; w_y = BLNK; w_z = BLNK; end
    endcase
  end

  // Decode register, held between captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_sign    <= 1'b0;
      o_zero    <= 1'b1;
      o_illegal <= 1'b0;
      o_x       <= BLNK;
      o_y       <= BLNK;
      o_z       <= BLNK;
    end else if (i_en) begin
      o_sign    <= i_dig[P_DIG_W];
      o_zero    <= (w_mag == {P_DIG_W{1'b0}});
      o_illegal <= mag_illegal(w_mag);
      o_x       <= w_x;
      o_y       <= w_y;
      o_z       <= w_z;
    end
  end

endmodule

// File: rtl/auc_wmul_ctrl.sv
// Window-NAF scalar-multiplication scheduler: walks the digit memory MSB
// first and issues LOAD/DBL/ADD commands to the point-arithmetic unit.
module auc_wmul_ctrl
  import auc_ecc_pkg::*;
#(
  parameter int ADDR   = P_ADDR,
  parameter int WINDOW = P_WINDOW,
  parameter int NLEN_W = P_NLEN_W,
  localparam int DIG_W = 1 << (WINDOW - 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wctl_start,
  input  logic [NLEN_W-1:0] wctl_nlen,
  output logic [NLEN_W-1:0] wctl_dig_addr,
  input  logic [DIG_W:0]    wctl_dig_vlue,
  output logic              wctl_cmd_vld,
  input  logic              wctl_cmd_rdy,
  output logic [1:0]        wctl_cmd_op,
  output logic              wctl_cmd_neg,
  output logic [ADDR-1:0]   wctl_paddx,
  output logic [ADDR-1:0]   wctl_paddy,
  output logic [ADDR-1:0]   wctl_paddz,
  input  logic              wctl_cmd_done,
  output logic              wctl_busy,
  output logic              wctl_done,
  output logic              wctl_inf,
  output logic              wctl_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [NLEN_W-1:0] r_idx;
  logic [NLEN_W-1:0] w_idx_nxt;
  logic              r_acc_valid;
  logic              w_acc_nxt;
  logic              r_err_flag;
  logic              w_err_nxt;

  logic              r_cmd_vld;
  logic [1:0]        r_cmd_op;
  logic              r_cmd_neg;
  logic [ADDR-1:0]   r_paddx;
  logic [ADDR-1:0]   r_paddy;
  logic [ADDR-1:0]   r_paddz;
  logic              r_busy;
  logic              r_done;
  logic              r_inf;
  logic              r_err;

  logic              w_dec_sign;
  logic              w_dec_zero;
  logic              w_dec_ill;
  logic [ADDR-1:0]   w_dec_x;
  logic [ADDR-1:0]   w_dec_y;
  logic [ADDR-1:0]   w_dec_z;

  auc_wmul_pdec #(.ADDR(ADDR)) u_pdec (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_state == ST_RDWAIT),
    .i_dig     (wctl_dig_vlue),
    .o_sign    (w_dec_sign),
    .o_zero    (w_dec_zero),
    .o_illegal (w_dec_ill),
    .o_x       (w_dec_x),
    .o_y       (w_dec_y),
    .o_z       (w_dec_z)
  );

  // Next-state, digit index and accumulator/error flag logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc_valid;
    w_err_nxt   = r_err_flag;
    case (r_state)
      ST_IDLE: begin
        if (wctl_start) begin
          w_acc_nxt = 1'b0;
          w_err_nxt = 1'b0;
          if (wctl_nlen == {NLEN_W{1'b0}}) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_idx_nxt   = wctl_nlen - NLEN_W'(1);
            w_state_nxt = ST_FETCH;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH:  w_state_nxt = ST_RDWAIT;
      ST_RDWAIT: w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (w_dec_ill) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_FIN;
        end else if (r_acc_valid) begin
          w_state_nxt = ST_DBL_REQ;
        end else if (w_dec_zero) begin
          w_state_nxt = ST_NEXT;
        end else begin
          w_state_nxt = ST_PT_REQ;
        end
      end
      ST_DBL_REQ: begin
        if (wctl_cmd_rdy) w_state_nxt = ST_DBL_WAIT;
        else              w_state_nxt = ST_DBL_REQ;
      end
      ST_DBL_WAIT: begin
        if (wctl_cmd_done) w_state_nxt = w_dec_zero ? ST_NEXT : ST_PT_REQ;
        else               w_state_nxt = ST_DBL_WAIT;
      end
      ST_PT_REQ: begin
        if (wctl_cmd_rdy) w_state_nxt = ST_PT_WAIT;
        else              w_state_nxt = ST_PT_REQ;
      end
      ST_PT_WAIT: begin
        if (wctl_cmd_done) begin
          w_acc_nxt   = 1'b1;
          w_state_nxt = ST_NEXT;
        end else begin
          w_state_nxt = ST_PT_WAIT;
        end
      end
      ST_NEXT: begin
        if (r_idx == {NLEN_W{1'b0}}) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_idx_nxt   = r_idx - NLEN_W'(1);
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= {NLEN_W{1'b0}};
      r_acc_valid <= 1'b0;
      r_err_flag  <= 1'b0;
      r_cmd_vld   <= 1'b0;
      r_cmd_op    <= OP_LOAD;
      r_cmd_neg   <= 1'b0;
      r_paddx     <= BLNK;
      r_paddy     <= BLNK;
      r_paddz     <= BLNK;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_inf       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_acc_valid <= w_acc_nxt;
      r_err_flag  <= w_err_nxt;
      r_cmd_vld   <= (w_state_nxt == ST_DBL_REQ) || (w_state_nxt == ST_PT_REQ);
      r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
      r_done      <= (w_state_nxt == ST_FIN);
      r_inf       <= (w_state_nxt == ST_FIN) && !w_acc_nxt && !w_err_nxt;
      r_err       <= (w_state_nxt == ST_FIN) && w_err_nxt;
      // Command fields only change on entry to a request state, so they stay stable until accepted.
      if (w_state_nxt == ST_DBL_REQ) begin
        r_cmd_op  <= OP_DBL;
        r_cmd_neg <= 1'b0;
        r_paddx   <= BLNK;
        r_paddy   <= BLNK;
        r_paddz   <= BLNK;
      end else if (w_state_nxt == ST_PT_REQ) begin
        r_cmd_op  <= r_acc_valid ? OP_ADD : OP_LOAD;
        r_cmd_neg <= w_dec_sign;
        r_paddx   <= w_dec_x;
        r_paddy   <= w_dec_y;
        r_paddz   <= w_dec_z;
      end
    end
  end

  assign wctl_dig_addr = r_idx;
  assign wctl_cmd_vld  = r_cmd_vld;
  assign wctl_cmd_op   = r_cmd_op;
  assign wctl_cmd_neg  = r_cmd_neg;
  assign wctl_paddx    = r_paddx;
  assign wctl_paddy    = r_paddy;
  assign wctl_paddz    = r_paddz;
  assign wctl_busy     = r_busy;
  assign wctl_done     = r_done;
  assign wctl_inf      = r_inf;
  assign wctl_err      = r_err;

endmodule

// File: tb/tb_auc_wmul_ctrl.sv
// Directed bench for auc_wmul_ctrl: NAF digit memory model plus a scripted
// point-arithmetic responder, checked against hand-computed command lists.
module tb_auc_wmul_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wctl_start = 1'b0;
  logic [8:0] wctl_nlen = 9'd0;
  logic [8:0] wctl_dig_addr;
  logic [4:0] wctl_dig_vlue = 5'd0;
  logic       wctl_cmd_vld;
  logic       wctl_cmd_rdy = 1'b0;
  logic [1:0] wctl_cmd_op;
  logic       wctl_cmd_neg;
  logic [4:0] wctl_paddx;
  logic [4:0] wctl_paddy;
  logic [4:0] wctl_paddz;
  logic       wctl_cmd_done = 1'b0;
  logic       wctl_busy;
  logic       wctl_done;
  logic       wctl_inf;
  logic       wctl_err;

  int n_checks = 0;
  int n_fail   = 0;
  int g_cyc    = 0;

  logic [4:0] dig_mem [0:15];
  logic [1:0] exp_op  [0:7];
  logic       exp_neg [0:7];
  logic [4:0] exp_x   [0:7];
  logic [4:0] exp_y   [0:7];
  logic [4:0] exp_z   [0:7];
  int         exp_n;
  logic       exp_inf;
  logic       exp_err;

  auc_wmul_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wctl_start    (wctl_start),
    .wctl_nlen     (wctl_nlen),
    .wctl_dig_addr (wctl_dig_addr),
    .wctl_dig_vlue (wctl_dig_vlue),
    .wctl_cmd_vld  (wctl_cmd_vld),
    .wctl_cmd_rdy  (wctl_cmd_rdy),
    .wctl_cmd_op   (wctl_cmd_op),
    .wctl_cmd_neg  (wctl_cmd_neg),
    .wctl_paddx    (wctl_paddx),
    .wctl_paddy    (wctl_paddy),
    .wctl_paddz    (wctl_paddz),
    .wctl_cmd_done (wctl_cmd_done),
    .wctl_busy     (wctl_busy),
    .wctl_done     (wctl_done),
    .wctl_inf      (wctl_inf),
    .wctl_err      (wctl_err)
  );

  always #5 clk = ~clk;

  // Digit memory with one cycle of read latency.
  always @(posedge clk) wctl_dig_vlue <= dig_mem[wctl_dig_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic [1:0] op, input logic neg,
                         input logic [4:0] x, input logic [4:0] y, input logic [4:0] z);
    exp_op[i] = op; exp_neg[i] = neg; exp_x[i] = x; exp_y[i] = y; exp_z[i] = z;
  endtask

  // Starts an operation and plays the arithmetic unit until done, a timeout, or an abort.
  task automatic run_op(input int nlen, input int stall, input bit spurious, input int abort_at);
    int   cyc;
    int   ncmd;
    bit   fin;
    logic [17:0] snap;
    cyc = 0; ncmd = 0; fin = 1'b0;
    @(negedge clk);
    wctl_nlen = 9'(nlen); wctl_start = 1'b1;
    @(negedge clk);
    wctl_start = 1'b0;
    if (nlen != 0) begin
      check("busy_on", {31'd0, wctl_busy}, 32'd1);
      wctl_start = 1'b1; wctl_nlen = 9'd0;
      @(negedge clk);
      wctl_start = 1'b0;
    end
    while (!fin && cyc < 500) begin
      if (wctl_done) begin
        fin = 1'b1;
        check("inf", {31'd0, wctl_inf}, {31'd0, exp_inf});
        check("err", {31'd0, wctl_err}, {31'd0, exp_err});
        check("cmd_count", ncmd, exp_n);
        check("busy_at_done", {31'd0, wctl_busy}, 32'd0);
      end else if (wctl_cmd_vld) begin
        if (ncmd < exp_n) begin
          check("op", {30'd0, wctl_cmd_op}, {30'd0, exp_op[ncmd]});
          check("neg", {31'd0, wctl_cmd_neg}, {31'd0, exp_neg[ncmd]});
          check("xyz", {17'd0, wctl_paddx, wctl_paddy, wctl_paddz},
                {17'd0, exp_x[ncmd], exp_y[ncmd], exp_z[ncmd]});
        end else begin
          check("extra_cmd", ncmd + 1, exp_n);
        end
        snap = {wctl_cmd_op, wctl_cmd_neg, wctl_paddx, wctl_paddy, wctl_paddz};
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          cyc++;
          check("vld_hold", {31'd0, wctl_cmd_vld}, 32'd1);
          check("fld_hold", {14'd0, wctl_cmd_op, wctl_cmd_neg, wctl_paddx, wctl_paddy, wctl_paddz},
                {14'd0, snap});
        end
        wctl_cmd_rdy = 1'b1; wctl_cmd_done = spurious;
        @(negedge clk);
        wctl_cmd_rdy = 1'b0; wctl_cmd_done = 1'b0; cyc++;
        check("vld_drop", {31'd0, wctl_cmd_vld}, 32'd0);
        if (ncmd == abort_at) begin
          rst = 1'b0;
          #1;
          check("rst_vld", {31'd0, wctl_cmd_vld}, 32'd0);
          check("rst_busy", {31'd0, wctl_busy}, 32'd0);
          check("rst_padd", {17'd0, wctl_paddx, wctl_paddy, wctl_paddz}, {17'd0, 15'h7fff});
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("rst_no_done", {31'd0, wctl_done}, 32'd0);
          end
          rst = 1'b1;
          return;
        end
        if (spurious) begin
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            cyc++;
            check("spur_ignored", {29'd0, wctl_done, wctl_cmd_vld, wctl_busy}, 32'd1);
          end
        end
        wctl_cmd_done = 1'b1;
        @(negedge clk);
        wctl_cmd_done = 1'b0; ncmd++; cyc++;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", {31'd0, fin}, 32'd1);
    g_cyc = cyc;
    if (fin) begin
      wctl_start = 1'b1; wctl_nlen = 9'd0;
      @(negedge clk);
      wctl_start = 1'b0;
      check("fin_start_ign", {30'd0, wctl_done, wctl_busy}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dig_mem[i] = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_vld0", {31'd0, wctl_cmd_vld}, 32'd0);
    check("rst_flags0", {28'd0, wctl_busy, wctl_done, wctl_inf, wctl_err}, 32'd0);
    check("rst_op0", {29'd0, wctl_cmd_op, wctl_cmd_neg}, 32'd0);
    check("rst_padd0", {17'd0, wctl_paddx, wctl_paddy, wctl_paddz}, {17'd0, 15'h7fff});
    check("rst_addr0", {23'd0, wctl_dig_addr}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // G, zero, -3G
    dig_mem[2] = 5'b0_1000; dig_mem[1] = 5'b0_0000; dig_mem[0] = 5'b1_0100;
    set_cmd(0, 2'b00, 1'b0, 5'd0, 5'd1, 5'd19);
    set_cmd(1, 2'b01, 1'b0, 5'd31, 5'd31, 5'd31);
    set_cmd(2, 2'b01, 1'b0, 5'd31, 5'd31, 5'd31);
    set_cmd(3, 2'b10, 1'b1, 5'd2, 5'd3, 5'd4);
    exp_n = 4; exp_inf = 1'b0; exp_err = 1'b0;
    run_op(3, 0, 1'b0, -1);

    // All-zero digits: eight cycles of fetch/decode/next, no commands
    dig_mem[1] = 5'd0; dig_mem[0] = 5'd0;
    exp_n = 0; exp_inf = 1'b1; exp_err = 1'b0;
    run_op(2, 0, 1'b0, -1);
    check("zero_latency", g_cyc, 7);

    // Empty scalar
    exp_n = 0; exp_inf = 1'b1; exp_err = 1'b0;
    run_op(0, 0, 1'b0, -1);
    check("nlen0_latency", g_cyc, 0);
    check("nlen0_addr", {23'd0, wctl_dig_addr}, 32'd0);

    // Illegal digit at idx 1 after LOAD and DBL
    dig_mem[3] = 5'b0_1000; dig_mem[2] = 5'b0_0000; dig_mem[1] = 5'b0_0110; dig_mem[0] = 5'b0_0001;
    set_cmd(0, 2'b00, 1'b0, 5'd0, 5'd1, 5'd19);
    set_cmd(1, 2'b01, 1'b0, 5'd31, 5'd31, 5'd31);
    exp_n = 2; exp_inf = 1'b0; exp_err = 1'b1;
    run_op(4, 0, 1'b0, -1);

    // Stalled ready and a done in the accept cycle, -5G
    dig_mem[0] = 5'b1_0010;
    set_cmd(0, 2'b00, 1'b1, 5'd5, 5'd6, 5'd7);
    exp_n = 1; exp_inf = 1'b0; exp_err = 1'b0;
    run_op(1, 5, 1'b1, -1);

    // Reset while waiting for a DBL, then a clean 7G restart
    dig_mem[1] = 5'b0_1000; dig_mem[0] = 5'b0_0000;
    set_cmd(0, 2'b00, 1'b0, 5'd0, 5'd1, 5'd19);
    set_cmd(1, 2'b01, 1'b0, 5'd31, 5'd31, 5'd31);
    exp_n = 2; exp_inf = 1'b0; exp_err = 1'b0;
    run_op(2, 0, 1'b0, 1);
    dig_mem[0] = 5'b0_0001;
    set_cmd(0, 2'b00, 1'b0, 5'd8, 5'd9, 5'd10);
    exp_n = 1; exp_inf = 1'b0; exp_err = 1'b0;
    run_op(1, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
